pipe_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register that succeeds the fixed-field MEM/WB latch.

---
 rtl/pipe_skid_reg_if.sv | 29 ++
 rtl/pipe_skid_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_skid_reg.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if
//   Handshake bundle between an upstream producer, the pipe_skid_reg stage and
//   a downstream consumer.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : the pipeline stage (drives in_ready, out_*)
//   in_valid/in_ready/in_data/in_halt     upstream offer and acceptance
//   out_valid/out_ready/out_data/out_halt downstream offer and acceptance
interface pipe_skid_reg_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_halt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_halt;

    modport master (
        output in_valid, in_data, in_halt, out_ready,
        input  in_ready, out_valid, out_data, out_halt
    );

    modport slave (
        input  in_valid, in_data, in_halt, out_ready,
        output in_ready, out_valid, out_data, out_halt
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline-stage register with a 2-entry skid buffer, flush, sticky halt and a
//   saturating downstream-stall counter. Payload is opaque (DATA_W bits) plus a
//   halt flag. in_ready is a function of registered state only, so upstream is
//   never combinationally stalled by downstream ready.
// Ports
//   CLK        clock, posedge
//   nRST       asynchronous reset, active-low
//   flush      discard all held entries; wins over accept/pop
//   bus        pipe_skid_reg_if.slave handshake bundle
//   halted     sticky: a halt entry has been consumed downstream
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
// Configuration
//   PIPE_SKID_BYPASS_EN  when defined, an input arriving while EMPTY with
//                        out_ready=1 passes straight through without storage.
//
// state | meaning
// ------+-----------------------------------
// EMPTY | no entry held
// HALF  | one entry held, in head
// FULL  | two entries held, head + skid
module pipe_skid_reg #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    pipe_skid_reg_if.slave    bus,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d, skid_q, skid_d;
    logic              head_halt_q, head_halt_d, skid_halt_q, skid_halt_d;
    logic              halt_seen_q, halt_seen_d;
    logic              halted_q, halted_d;
    logic              rdy_en_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_ready_w, out_valid_w, out_halt_w;
    logic [DATA_W-1:0] out_data_w;
    logic              bypass, acc, pop;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= EMPTY;
            head_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            head_halt_q <= 1'b0;
            skid_halt_q <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            rdy_en_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            head_halt_q <= head_halt_d;
            skid_halt_q <= skid_halt_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
            rdy_en_q    <= 1'b1;    // keeps in_ready low until the first edge after reset
            cnt_q       <= cnt_d;
        end
    end

    // Output logic
    always_comb begin
        in_ready_w = (state_q != FULL) & rdy_en_q & ~halted_q & ~halt_seen_q;
        bypass     = 1'b0;
`ifdef PIPE_SKID_BYPASS_EN
        bypass     = (state_q == EMPTY) & bus.in_valid & bus.out_ready & in_ready_w & ~flush;
`endif
        out_valid_w = ((state_q != EMPTY) & ~halted_q) | bypass;
        out_data_w  = bypass ? bus.in_data : head_q;
        out_halt_w  = bypass ? bus.in_halt : head_halt_q;
        acc         = bus.in_valid & in_ready_w;
        pop         = out_valid_w & bus.out_ready;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.out_halt  = out_halt_w;
    assign halted        = halted_q;
    assign stall_cnt     = cnt_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        skid_d      = skid_q;
        head_halt_d = head_halt_q;
        skid_halt_d = skid_halt_q;

        if (flush) begin
            state_d     = EMPTY;
            head_d      = RST_VAL;
            skid_d      = RST_VAL;
            head_halt_d = 1'b0;
            skid_halt_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc && !bypass) begin
                        state_d     = HALF;
                        head_d      = bus.in_data;
                        head_halt_d = bus.in_halt;
                    end
                end
                HALF: begin
                    if (acc && !pop) begin
                        state_d     = FULL;
                        skid_d      = bus.in_data;
                        skid_halt_d = bus.in_halt;
                    end else if (pop && !acc) begin
                        state_d = EMPTY;
                    end else if (acc && pop) begin
                        head_d      = bus.in_data;
                        head_halt_d = bus.in_halt;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d     = HALF;
                        head_d      = skid_q;
                        head_halt_d = skid_halt_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        halt_seen_d = flush ? 1'b0 : (halt_seen_q | (acc & bus.in_halt));
        // A flushed head is not considered consumed, even if downstream was ready.
        halted_d    = halted_q | (pop & out_halt_w & ~flush);

        cnt_d = cnt_q;
        if (out_valid_w && !bus.out_ready && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;
    localparam int          DATA_W  = 32;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    pipe_skid_reg_if #(.DATA_W(DATA_W)) bus ();

    pipe_skid_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL), .CNT_W(CNT_W)) dut (
        .CLK       (clk),
        .nRST      (rst_n),
        .flush     (flush),
        .bus       (bus),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Behavioural model: a FIFO of {halt,data} entries, capacity 2.
    logic [DATA_W:0] mq[$];
    bit m_halted = 0, m_halt_seen = 0, m_rdy_en = 0;
    int m_cnt = 0;

    function automatic bit m_in_ready();
        return m_rdy_en && (mq.size() < 2) && !m_halted && !m_halt_seen;
    endfunction

    function automatic bit m_out_valid();
        return (mq.size() > 0) && !m_halted;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_halted = 0; m_halt_seen = 0; m_rdy_en = 0; m_cnt = 0;
        end else begin
            bit acc, pop;
            acc = bus.in_valid && m_in_ready();
            pop = m_out_valid() && bus.out_ready;
            if (m_out_valid() && !bus.out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                mq.delete();
                m_halt_seen = 0;
            end else begin
                if (pop) begin
                    if (mq[0][DATA_W]) m_halted = 1;
                    void'(mq.pop_front());
                end
                if (acc) begin
                    mq.push_back({bus.in_halt, bus.in_data});
                    if (bus.in_halt) m_halt_seen = 1;
                end
            end
            m_rdy_en = 1;
        end
    end

    // Per-cycle compare plus a log of what downstream actually took.
    logic [31:0] plog[$];
    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, m_in_ready());
        chk("out_valid", bus.out_valid, m_out_valid());
        chk("halted", halted, m_halted);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (m_out_valid()) begin
            logic [DATA_W:0] e;
            e = mq[0];
            chk("out_data", bus.out_data, e[DATA_W-1:0]);
            chk("out_halt", bus.out_halt, e[DATA_W]);
        end
        if (rst_n && !flush && bus.out_valid && bus.out_ready) plog.push_back(bus.out_data);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic h);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_halt  = h;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_halt   = 1'b0;
        bus.out_ready = 1'b0;

        // T1: reset values and in_ready release timing
        #1 rst_n = 1'b0;
        cyc(); cyc();
        chk("t1_out_valid", bus.out_valid, 1'b0);
        chk("t1_out_data", bus.out_data, RST_VAL);
        chk("t1_out_halt", bus.out_halt, 1'b0);
        chk("t1_stall", stall_cnt, 0);
        chk("t1_in_ready_rst", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        #1 chk("t1_in_ready_rel", bus.in_ready, 1'b0);
        cyc();
        chk("t1_in_ready_up", bus.in_ready, 1'b1);

        // T2: streaming, one cycle behind, no bubbles
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(i, 1'b0);
            chk("t2_valid", bus.out_valid, 1'b1);
            chk("t2_head", bus.out_data, i);
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("t2_drained", bus.out_valid, 1'b0);
        chk("t2_log_n", plog.size(), 8);
        for (int k = 0; k < plog.size(); k++) chk("t2_log", plog[k], k + 1);
        plog.delete();

        // T3: backpressure fills the skid, stall counter advances
        bus.out_ready = 1'b0;
        push(32'hA, 1'b0);
        push(32'hB, 1'b0);
        bus.in_data = 32'hC;
        repeat (3) cyc();
        chk("t3_in_ready", bus.in_ready, 1'b0);
        chk("t3_stall", stall_cnt, 4);
        chk("t3_head", bus.out_data, 32'hA);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc(); cyc();
        chk("t3_drained", bus.out_valid, 1'b0);
        chk("t3_stall_hold", stall_cnt, 4);
        chk("t3_log_n", plog.size(), 2);
        if (plog.size() == 2) begin
            chk("t3_log0", plog[0], 32'hA);
            chk("t3_log1", plog[1], 32'hB);
        end
        plog.delete();

        // T1 again: reset while entries are held
        bus.out_ready = 1'b0;
        push(32'h11, 1'b0);
        push(32'h12, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1m_out_valid", bus.out_valid, 1'b0);
        chk("t1m_out_data", bus.out_data, RST_VAL);
        chk("t1m_stall", stall_cnt, 0);
        chk("t1m_in_ready", bus.in_ready, 1'b0);
        cyc();
        rst_n = 1'b1;
        #1 chk("t1m_in_ready_rel", bus.in_ready, 1'b0);
        cyc();
        chk("t1m_in_ready_up", bus.in_ready, 1'b1);

        // T4: flush while FULL, with a competing input and a ready downstream
        push(32'h21, 1'b0);
        push(32'h22, 1'b0);
        chk("t4_full", bus.in_ready, 1'b0);
        flush         = 1'b1;
        bus.in_data   = 32'h23;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t4_empty", bus.out_valid, 1'b0);
        chk("t4_in_ready", bus.in_ready, 1'b1);
        cyc();
        chk("t4_dropped", bus.out_valid, 1'b0);
        chk("t4_log_n", plog.size(), 0);
        plog.delete();

        // T5: halt blocks further input and sticks after it pops
        bus.out_ready = 1'b0;
        push(32'h5, 1'b0);
        push(32'h6, 1'b1);
        chk("t5_block", bus.in_ready, 1'b0);
        push(32'h7, 1'b0);
        chk("t5_refuse", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        cyc();
        chk("t5_not_yet", halted, 1'b0);
        chk("t5_head6", bus.out_data, 32'h6);
        chk("t5_head6_halt", bus.out_halt, 1'b1);
        cyc();
        chk("t5_halted", halted, 1'b1);
        chk("t5_out_valid", bus.out_valid, 1'b0);
        chk("t5_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        cyc();
        chk("t5_stay", bus.out_valid, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t5_flush_keep", halted, 1'b1);
        chk("t5_log_n", plog.size(), 2);
        if (plog.size() == 2) begin
            chk("t5_log0", plog[0], 32'h5);
            chk("t5_log1", plog[1], 32'h6);
        end
        plog.delete();

        // T6: stall counter saturates at 2**CNT_W-1
        rst_n = 1'b0;
        #1 cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_unhalted", halted, 1'b0);
        bus.out_ready = 1'b0;
        push(32'h31, 1'b0);
        bus.in_valid = 1'b0;
        repeat (10) cyc();
        chk("t6_cnt10", stall_cnt, 10);
        repeat (10) cyc();
        chk("t6_sat", stall_cnt, 15);
        chk("t6_head", bus.out_data, 32'h31);
        chk("t6_valid", bus.out_valid, 1'b1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
